// File: rtl/progmem_loader.sv
// progmem_loader: boot loader that receives a framed byte image
// (A5, LEN_LO, LEN_HI, 4*N data bytes, CSUM), writes it word by word into
// program memory over an Avalon-style master port and keeps the CPU in
// reset until a complete image has loaded with a valid checksum.
module progmem_loader #(
    parameter int          ADDR_WIDTH     = 12,
    parameter int unsigned MAX_WORDS      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [ADDR_WIDTH-1:0] o_ctrl_address,
    output logic                  o_ctrl_read,
    output logic                  o_ctrl_write,
    output logic [31:0]           o_ctrl_writedata,
    input  logic                  i_ctrl_waitrequest,
    output logic                  o_cpu_rst_hold,
    output logic                  o_load_busy,
    output logic                  o_load_done,
    output logic [1:0]            o_load_err
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [2:0]            r_state;
    logic                  r_rx_ready;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [31:0]           r_word;
    logic [1:0]            r_bcnt;
    logic [7:0]            r_acc;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [GW-1:0]         r_gap;
    logic                  r_ctrl_write;
    logic [ADDR_WIDTH-1:0] r_ctrl_address;
    logic [31:0]           r_ctrl_writedata;
    logic                  r_hold;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_err;

    logic                  w_xfer;
    logic [15:0]           w_len;
    logic                  w_len_bad;
    logic [7:0]            w_acc_next;
    logic [31:0]           w_word_next;
    logic                  w_last_word;
    logic                  w_gap_run;
    logic                  w_timeout;
    logic [2:0]            w_state_next;

    assign w_xfer      = i_rx_valid && r_rx_ready;
    assign w_len       = {i_rx_data, r_len_lo};
    assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > MAX_WORDS);
    assign w_acc_next  = r_acc + i_rx_data;
    assign w_word_next = {i_rx_data, r_word[31:8]};
    assign w_last_word = (32'(r_widx) + 32'd1) == 32'(r_len);
    assign w_gap_run   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_timeout   = w_gap_run && !w_xfer &&
                         ((32'(r_gap) + 32'd1) == TIMEOUT_CYCLES);

    assign o_rx_ready       = r_rx_ready;
    assign o_ctrl_address   = r_ctrl_address;
    assign o_ctrl_read      = 1'b0;
    assign o_ctrl_write     = r_ctrl_write;
    assign o_ctrl_writedata = r_ctrl_writedata;
    assign o_cpu_rst_hold   = r_hold;
    assign o_load_busy      = r_busy;
    assign o_load_done      = r_done;
    assign o_load_err       = r_err;

    // Frame sequencing: next state from the accepted byte, write completion and timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && (i_rx_data == SYNC_BYTE)) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_timeout)   w_state_next = S_IDLE;
                else if (w_xfer) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_timeout)   w_state_next = S_IDLE;
                else if (w_xfer) w_state_next = w_len_bad ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_timeout)                       w_state_next = S_IDLE;
                else if (w_xfer && (r_bcnt == 2'd3)) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (!i_ctrl_waitrequest) w_state_next = w_last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_timeout || w_xfer) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, handshake, datapath and status registers.
    // rx_ready is registered from the next state so it is low during reset and
    // exactly covers the WRITE cycles without a combinational path from state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_rx_ready       <= 1'b0;
            r_len_lo         <= '0;
            r_len            <= '0;
            r_word           <= '0;
            r_bcnt           <= '0;
            r_acc            <= '0;
            r_widx           <= '0;
            r_gap            <= '0;
            r_ctrl_write     <= 1'b0;
            r_ctrl_address   <= '0;
            r_ctrl_writedata <= '0;
            r_hold           <= 1'b1;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= ERR_NONE;
        end else begin
            r_state    <= w_state_next;
            r_rx_ready <= (w_state_next != S_WRITE);

            // Inter-byte gap: runs while waiting for frame bytes, frozen during a write.
            if (w_gap_run) begin
                if (w_xfer || w_timeout) r_gap <= '0;
                else                     r_gap <= r_gap + GW'(1);
            end else if (r_state == S_IDLE) begin
                r_gap <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_xfer && (i_rx_data == SYNC_BYTE)) begin
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_err  <= ERR_NONE;
                        r_hold <= 1'b1;
                        r_acc  <= '0;
                        r_widx <= '0;
                        r_bcnt <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) r_len_lo <= i_rx_data;
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_err  <= ERR_LEN;
                            r_busy <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_acc  <= w_acc_next;
                        r_word <= w_word_next;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_ctrl_write     <= 1'b1;
                            r_ctrl_address   <= r_widx;
                            r_ctrl_writedata <= w_word_next;
                        end
                    end
                end
                S_WRITE: begin
                    if (!i_ctrl_waitrequest) begin
                        r_ctrl_write <= 1'b0;
                        r_widx       <= r_widx + ADDR_WIDTH'(1);
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_busy <= 1'b0;
                        if (w_acc_next == 8'd0) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err <= ERR_CSUM;
                        end
                    end
                end
                default: ;
            endcase

            if (w_timeout) begin
                r_err  <= ERR_TIMEOUT;
                r_busy <= 1'b0;
                r_bcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_progmem_loader.sv
// tb_progmem_loader: directed frames against progmem_loader with a
// byte-position frame model checked every cycle, plus literal expectations.
module tb_progmem_loader;

    localparam int          AW = 12;
    localparam int unsigned MW = 4096;
    localparam int unsigned TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          wreq = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] ctrl_address;
    logic          ctrl_read;
    logic          ctrl_write;
    logic [31:0]   ctrl_writedata;
    logic          cpu_rst_hold;
    logic          load_busy;
    logic          load_done;
    logic [1:0]    load_err;

    always #5 clk = ~clk;

    progmem_loader #(
        .ADDR_WIDTH     (AW),
        .MAX_WORDS      (MW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rx_data          (rx_data),
        .i_rx_valid         (rx_valid),
        .o_rx_ready         (rx_ready),
        .o_ctrl_address     (ctrl_address),
        .o_ctrl_read        (ctrl_read),
        .o_ctrl_write       (ctrl_write),
        .o_ctrl_writedata   (ctrl_writedata),
        .i_ctrl_waitrequest (wreq),
        .o_cpu_rst_hold     (cpu_rst_hold),
        .o_load_busy        (load_busy),
        .o_load_done        (load_done),
        .o_load_err         (load_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: tracks position of the next byte within the frame.
    bit          m_in_frame;
    int          m_pos, m_len, m_sum, m_gap;
    logic [31:0] m_buf;
    bit          m_ready, m_wr;
    int          m_wr_addr;
    logic [31:0] m_wr_data;
    bit          m_hold, m_busy, m_done;
    logic [1:0]  m_err;

    // Writes observed on the DUT bus, with how many cycles each strobe stayed high.
    int          log_addr[$];
    logic [31:0] log_data[$];
    int          log_hi[$];
    int          wr_hi = 0;
    int          stall_left = 0;

    task automatic model_reset();
        m_in_frame = 0; m_pos = 0; m_len = 0; m_sum = 0; m_gap = 0; m_buf = '0;
        m_ready = 0; m_wr = 0; m_wr_addr = 0; m_wr_data = '0;
        m_hold = 1; m_busy = 0; m_done = 0; m_err = 2'b00;
    endtask

    task automatic model_step();
        int d;
        if (m_wr) begin
            if (!wreq) m_wr = 0;
        end else if (rx_valid && m_ready) begin
            if (!m_in_frame) begin
                if (rx_data == 8'hA5) begin
                    m_in_frame = 1; m_pos = 0; m_sum = 0; m_gap = 0;
                    m_busy = 1; m_done = 0; m_err = 2'b00; m_hold = 1;
                end
            end else begin
                m_gap = 0;
                if (m_pos == 0) begin
                    m_len = int'(rx_data);
                end else if (m_pos == 1) begin
                    m_len = m_len + int'(rx_data) * 256;
                    if (m_len == 0 || m_len > int'(MW)) begin
                        m_err = 2'b10; m_busy = 0; m_in_frame = 0;
                    end
                end else if (m_pos < 2 + 4 * m_len) begin
                    d = m_pos - 2;
                    m_sum = m_sum + int'(rx_data);
                    m_buf[8*(d%4) +: 8] = rx_data;
                    if (d % 4 == 3) begin
                        m_wr = 1; m_wr_addr = d / 4; m_wr_data = m_buf;
                    end
                end else begin
                    if ((m_sum + int'(rx_data)) % 256 == 0) begin
                        m_done = 1; m_hold = 0;
                    end else begin
                        m_err = 2'b01;
                    end
                    m_busy = 0; m_in_frame = 0;
                end
                m_pos++;
            end
        end else if (m_in_frame) begin
            m_gap++;
            if (m_gap == int'(TO)) begin
                m_err = 2'b11; m_busy = 0; m_in_frame = 0;
            end
        end
        m_ready = !m_wr;
    endtask

    // Compare DUT outputs with the model mid-cycle, then advance the model by this cycle.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            wr_hi = 0;
        end else begin
            check("rx_ready", rx_ready, m_ready);
            check("ctrl_write", ctrl_write, m_wr);
            check("ctrl_read", ctrl_read, 0);
            if (m_wr) begin
                check("ctrl_address", ctrl_address, m_wr_addr);
                check("ctrl_writedata", ctrl_writedata, m_wr_data);
            end
            check("cpu_rst_hold", cpu_rst_hold, m_hold);
            check("load_busy", load_busy, m_busy);
            check("load_done", load_done, m_done);
            check("load_err", load_err, m_err);
            if (ctrl_write) begin
                wr_hi++;
                if (!wreq) begin
                    log_addr.push_back(int'(ctrl_address));
                    log_data.push_back(ctrl_writedata);
                    log_hi.push_back(wr_hi);
                    wr_hi = 0;
                end
            end
            model_step();
        end
    end

    // Slave stall generator: holds waitrequest for stall_left cycles of a write.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ctrl_write && stall_left > 0) begin
                wreq = 1'b1;
                stall_left--;
            end else begin
                wreq = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("handshake", got, 1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_hi.delete();
    endtask

    task automatic check_status(input string tag, input bit done, input bit hold,
                                input bit busy, input logic [1:0] err);
        check({tag, ".done"}, load_done, done);
        check({tag, ".hold"}, cpu_rst_hold, hold);
        check({tag, ".busy"}, load_busy, busy);
        check({tag, ".err"}, load_err, err);
    endtask

    task automatic check_write(input string tag, input int idx, input int addr,
                               input logic [31:0] data);
        check({tag, ".nwr"}, (log_data.size() > idx) ? 1 : 0, 1);
        if (log_data.size() > idx) begin
            check({tag, ".addr"}, log_addr[idx], addr);
            check({tag, ".data"}, log_data[idx], data);
        end
    endtask

    // Data byte sum 0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44C, so CSUM 0xB4 zeroes it.
    logic [7:0] f_good [12] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4};
    // A5 inside the payload is plain data; sum 0x29E, CSUM 0x62.
    logic [7:0] f_sync [12] = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                8'h01, 8'h02, 8'h03, 8'h04, 8'h62};
    logic [7:0] f_bad  [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        f_bad = f_good;
        f_bad[11] = 8'hB5;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rx_ready", rx_ready, 0);
        check("rst.ctrl_write", ctrl_write, 0);
        check("rst.ctrl_address", ctrl_address, 0);
        check("rst.ctrl_writedata", ctrl_writedata, 0);
        check_status("rst", 0, 1, 0, 2'b00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Good two-word image.
        clear_log();
        for (int i = 0; i < 12; i++) send_byte(f_good[i]);
        check_status("good", 1, 0, 0, 2'b00);
        check("good.count", log_data.size(), 2);
        check_write("good.w0", 0, 0, 32'h12345678);
        check_write("good.w1", 1, 1, 32'hDEADBEEF);

        // Idle garbage is dropped, then a new sync re-holds the CPU.
        send_byte(8'h00);
        send_byte(8'hFF);
        check_status("garbage", 1, 0, 0, 2'b00);
        clear_log();
        send_byte(8'hA5);
        check_status("resync", 0, 1, 1, 2'b00);
        for (int i = 1; i < 12; i++) send_byte(f_bad[i]);
        check_status("badcsum", 0, 1, 0, 2'b01);
        check("badcsum.count", log_data.size(), 2);
        check_write("badcsum.w0", 0, 0, 32'h12345678);
        check_write("badcsum.w1", 1, 1, 32'hDEADBEEF);

        // Zero length and over-length images.
        clear_log();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_status("len0", 0, 1, 0, 2'b10);
        check("len0.count", log_data.size(), 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        repeat (3) @(posedge clk);
        #1;
        check_status("len1001", 0, 1, 0, 2'b10);
        check("len1001.count", log_data.size(), 0);

        // Five-cycle stall on word 0 of a payload containing A5 bytes.
        clear_log();
        stall_left = 5;
        send_byte(f_sync[0]);
        check_status("stall.sync", 0, 1, 1, 2'b00);
        for (int i = 1; i < 12; i++) send_byte(f_sync[i]);
        check_status("stall", 1, 0, 0, 2'b00);
        check("stall.count", log_data.size(), 2);
        check_write("stall.w0", 0, 0, 32'hA5A5A5A5);
        check_write("stall.w1", 1, 1, 32'h04030201);
        if (log_hi.size() == 2) begin
            check("stall.w0_cycles", log_hi[0], 6);
            check("stall.w1_cycles", log_hi[1], 1);
        end

        // Stall after two data bytes until the gap limit aborts the frame.
        clear_log();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56);
        cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (load_err == 2'b11) begin
                cnt = k;
                break;
            end
        end
        check("timeout.cycles", cnt, 101);
        check_status("timeout", 0, 1, 0, 2'b11);
        check("timeout.count", log_data.size(), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) send_byte(f_good[i]);
        check_status("after_to", 1, 0, 0, 2'b00);
        check_write("after_to.w0", 0, 0, 32'h12345678);
        check_write("after_to.w1", 1, 1, 32'hDEADBEEF);

        // Asynchronous reset while a write is stalled.
        stall_left = 20;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("midrst.write_before", ctrl_write, 1);
        check("midrst.addr_before", ctrl_address, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.ctrl_write", ctrl_write, 0);
        check("midrst.rx_ready", rx_ready, 0);
        check("midrst.ctrl_address", ctrl_address, 0);
        check_status("midrst", 0, 1, 0, 2'b00);
        stall_left = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_log();
        for (int i = 0; i < 12; i++) send_byte(f_good[i]);
        check_status("post_rst", 1, 0, 0, 2'b00);
        check_write("post_rst.w1", 1, 1, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
